regfile_cmd_ctrl: RTL and testbench

Command front-end for the register file: parses byte frames from the UART receiver and turns them into single-cycle write/read strobes on the register-file port. It also collects read data and hands it to the UART transmitter path. It sits between the UART RX deserializer and the register file, with a byte output toward the TX FIFO.

---
 rtl/regfile_cmd_pkg.sv | 16 +
 rtl/regfile_cmd_timer.sv | 37 +++
 rtl/regfile_cmd_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_regfile_cmd_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_cmd_pkg.sv
// Shared types and command codes for the register-file command front-end.
package regfile_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      TX_SEND
   } state_t;

   localparam logic [7:0] CMD_WR = 8'hAA;
   localparam logic [7:0] CMD_RD = 8'hBB;

endpackage

// File: rtl/regfile_cmd_timer.sv
// Frame inactivity counter: counts enabled cycles, cleared by clr, flags expire on the
// cycle the count would reach TIMEOUT.
module regfile_cmd_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign expire = en && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/regfile_cmd_ctrl.sv
// UART byte-frame parser driving register-file write/read strobes and returning read data to TX.
// Optional inactivity abort of partial frames is built with REGFILE_CMD_TIMEOUT_EN.
module regfile_cmd_ctrl
   import regfile_cmd_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned ADDR    = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] RX_P_DATA,
   input  logic             RX_D_VLD,
   output logic             WrEn,
   output logic             RdEn,
   output logic [ADDR-1:0]  Address,
   output logic [WIDTH-1:0] WrData,
   input  logic [WIDTH-1:0] RdData,
   input  logic             RdData_VLD,
   output logic [WIDTH-1:0] TX_P_DATA,
   output logic             TX_D_VLD,
   input  logic             TX_BUSY,
   output logic             FRAME_ERR
);

   state_t           state_q,     state_d;
   logic             wr_en_q,     wr_en_d;
   logic             rd_en_q,     rd_en_d;
   logic [ADDR-1:0]  addr_q,      addr_d;
   logic [WIDTH-1:0] wr_data_q,   wr_data_d;
   logic [WIDTH-1:0] tx_data_q,   tx_data_d;
   logic             tx_vld_q,    tx_vld_d;
   logic             frame_err_q, frame_err_d;

   logic addr_ok;
   logic byte_acc;

   assign addr_ok  = (RX_P_DATA[WIDTH-1:ADDR] == '0);
   // Bytes arriving while a read is in flight are dropped, not accepted.
   assign byte_acc = RX_D_VLD && !(state_q inside {RD_WAIT, TX_SEND});

`ifdef REGFILE_CMD_TIMEOUT_EN
   logic tmr_en;
   logic tmr_clr;
   logic tmr_expire;

   assign tmr_en  = state_q inside {WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT};
   assign tmr_clr = byte_acc || (state_d != state_q);

   regfile_cmd_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk    (CLK),
      .rst_n  (RST),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expire (tmr_expire)
   );
`else
   logic [31:0] unused_timeout;
   assign unused_timeout = TIMEOUT;
`endif

   always_comb begin
      state_d     = state_q;
      wr_en_d     = 1'b0;
      rd_en_d     = 1'b0;
      addr_d      = addr_q;
      wr_data_d   = wr_data_q;
      tx_data_d   = tx_data_q;
      tx_vld_d    = 1'b0;
      frame_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == WIDTH'(CMD_WR)) begin
                  state_d = WR_ADDR;
               end else if (RX_P_DATA == WIDTH'(CMD_RD)) begin
                  state_d = RD_ADDR;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         WR_ADDR: begin
            if (RX_D_VLD) begin
               if (addr_ok) begin
                  addr_d  = RX_P_DATA[ADDR-1:0];
                  state_d = WR_DATA;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = IDLE;
               end
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               wr_data_d = RX_P_DATA;
               wr_en_d   = 1'b1;
               state_d   = IDLE;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               if (addr_ok) begin
                  addr_d  = RX_P_DATA[ADDR-1:0];
                  rd_en_d = 1'b1;
                  state_d = RD_WAIT;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = IDLE;
               end
            end
         end
         RD_WAIT: begin
            frame_err_d = RX_D_VLD;
            // An idle transmitter gets the byte straight away so the strobe lands
            // one cycle after the read data returns.
            if (RdData_VLD) begin
               tx_data_d = RdData;
               if (!TX_BUSY) begin
                  tx_vld_d = 1'b1;
                  state_d  = IDLE;
               end else begin
                  state_d  = TX_SEND;
               end
            end
         end
         TX_SEND: begin
            frame_err_d = RX_D_VLD;
            if (!TX_BUSY) begin
               tx_vld_d = 1'b1;
               state_d  = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef REGFILE_CMD_TIMEOUT_EN
      if (tmr_expire && !byte_acc && (state_d == state_q)) begin
         state_d     = IDLE;
         frame_err_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q     <= IDLE;
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         addr_q      <= '0;
         wr_data_q   <= '0;
         tx_data_q   <= '0;
         tx_vld_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_en_q     <= wr_en_d;
         rd_en_q     <= rd_en_d;
         addr_q      <= addr_d;
         wr_data_q   <= wr_data_d;
         tx_data_q   <= tx_data_d;
         tx_vld_q    <= tx_vld_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign WrEn      = wr_en_q;
   assign RdEn      = rd_en_q;
   assign Address   = addr_q;
   assign WrData    = wr_data_q;
   assign TX_P_DATA = tx_data_q;
   assign TX_D_VLD  = tx_vld_q;
   assign FRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Bench for regfile_cmd_ctrl: frame-level reference model feeds per-event expectation
// queues; an independent monitor pops and compares whenever the DUT strobes an output.
module tb_regfile_cmd_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] RX_P_DATA = 8'h00;
   logic       RX_D_VLD = 1'b0;
   logic       WrEn, RdEn;
   logic [3:0] Address;
   logic [7:0] WrData;
   logic [7:0] RdData = 8'h00;
   logic       RdData_VLD = 1'b0;
   logic [7:0] TX_P_DATA;
   logic       TX_D_VLD;
   logic       TX_BUSY = 1'b0;
   logic       FRAME_ERR;

   regfile_cmd_ctrl #(
      .WIDTH   (8),
      .ADDR    (4),
      .TIMEOUT (8)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RX_P_DATA  (RX_P_DATA),
      .RX_D_VLD   (RX_D_VLD),
      .WrEn       (WrEn),
      .RdEn       (RdEn),
      .Address    (Address),
      .WrData     (WrData),
      .RdData     (RdData),
      .RdData_VLD (RdData_VLD),
      .TX_P_DATA  (TX_P_DATA),
      .TX_D_VLD   (TX_D_VLD),
      .TX_BUSY    (TX_BUSY),
      .FRAME_ERR  (FRAME_ERR)
   );

   initial forever #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;

   // expectation queues, one per output event kind
   logic [11:0] wr_q[$];
   logic [3:0]  rd_q[$];
   logic [7:0]  tx_q[$];
   bit          err_q[$];

   logic [7:0] rf       [16];
   logic [7:0] exp_mem  [16];
   logic [7:0] frame[$];
   bit         rd_busy = 1'b0;
   int         rd_delay = 0;
   int         inject_req = 0;
   int         inject_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: interprets the byte stream as frames.
   task automatic model_byte(input logic [7:0] b);
      logic [7:0] hdr;
      logic [7:0] a;
      if (rd_busy) begin
         err_q.push_back(1'b1);
         return;
      end
      if (frame.size() == 0) begin
         if (b == 8'hAA || b == 8'hBB) frame.push_back(b);
         else err_q.push_back(1'b1);
         return;
      end
      frame.push_back(b);
      hdr = frame[0];
      if (frame.size() == 2 && b > 8'h0F) begin
         err_q.push_back(1'b1);
         frame.delete();
      end else if (hdr == 8'hBB) begin
         rd_q.push_back(b[3:0]);
         tx_q.push_back(exp_mem[b[3:0]]);
         rd_busy = 1'b1;
         frame.delete();
      end else if (frame.size() == 3) begin
         a = frame[1];
         wr_q.push_back({a[3:0], b});
         exp_mem[a[3:0]] = b;
         frame.delete();
      end
   endtask

   // Called at a negedge; returns at the negedge one cycle later.
   task automatic send_byte(input logic [7:0] b);
      model_byte(b);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
      RX_P_DATA = 8'($urandom);
   endtask

   task automatic wait_tx(output int lat, input bit rand_busy);
      lat = 0;
      for (int i = 1; i <= 300; i++) begin
         @(negedge CLK);
         if (TX_D_VLD) begin
            lat = i;
            break;
         end
         if (rand_busy) TX_BUSY = ($urandom_range(0, 2) == 0);
      end
      TX_BUSY = 1'b0;
      rd_busy = 1'b0;
      check("tx_arrived", lat > 0, 1);
   endtask

   task automatic reset_dut();
      RST = 1'b0;
      frame.delete();
      rd_busy = 1'b0;
      @(negedge CLK);
      check("rst_wren", WrEn, 0);
      check("rst_rden", RdEn, 0);
      check("rst_txvld", TX_D_VLD, 0);
      check("rst_ferr", FRAME_ERR, 0);
      check("rst_addr", Address, 0);
      check("rst_wrdata", WrData, 0);
      check("rst_txdata", TX_P_DATA, 0);
      RST = 1'b1;
   endtask

   // Register-file environment: one-cycle read latency plus optional extra delay.
   initial begin
      logic [3:0] a;
      forever begin
         @(negedge CLK);
         if (WrEn) rf[Address] = WrData;
         if (RdEn) begin
            a = Address;
            repeat (rd_delay) @(negedge CLK);
            @(posedge CLK);
            #1;
            RdData     = rf[a];
            RdData_VLD = 1'b1;
            @(posedge CLK);
            #1;
            RdData_VLD = 1'b0;
            RdData     = 8'h00;
         end else if (inject_done != inject_req) begin
            inject_done++;
            @(posedge CLK);
            #1;
            RdData     = 8'($urandom);
            RdData_VLD = 1'b1;
            @(posedge CLK);
            #1;
            RdData_VLD = 1'b0;
         end
      end
   end

   // Monitor: every strobe must match the head of its expectation queue.
   initial begin
      logic [11:0] w;
      forever begin
         @(negedge CLK);
         if (WrEn) begin
            check("wr_rd_exclusive", RdEn, 0);
            check("wren_expected", wr_q.size() > 0, 1);
            if (wr_q.size() > 0) begin
               w = wr_q.pop_front();
               check("wr_addr", Address, w[11:8]);
               check("wr_data", WrData, w[7:0]);
            end
         end
         if (RdEn) begin
            check("rden_expected", rd_q.size() > 0, 1);
            if (rd_q.size() > 0) check("rd_addr", Address, rd_q.pop_front());
         end
         if (TX_D_VLD) begin
            check("txvld_expected", tx_q.size() > 0, 1);
            if (tx_q.size() > 0) check("tx_data", TX_P_DATA, tx_q.pop_front());
         end
         if (FRAME_ERR) begin
            check("frame_err_expected", err_q.size() > 0, 1);
            if (err_q.size() > 0) void'(err_q.pop_front());
         end
      end
   end

   initial begin
      int  lat;
      bit  leak;
      int  kind;
      logic [7:0] b;

      for (int i = 0; i < 16; i++) begin
         rf[i]      = 8'($urandom);
         exp_mem[i] = rf[i];
      end
      repeat (2) @(negedge CLK);
      check("rst_wren", WrEn, 0);
      check("rst_rden", RdEn, 0);
      check("rst_txvld", TX_D_VLD, 0);
      check("rst_ferr", FRAME_ERR, 0);
      check("rst_addr", Address, 0);
      check("rst_wrdata", WrData, 0);
      check("rst_txdata", TX_P_DATA, 0);
      RST = 1'b1;
      @(negedge CLK);

      // write then read back-to-back
      send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
      check("wren_latency", WrEn, 1);
      send_byte(8'hBB); send_byte(8'h05);
      wait_tx(lat, 1'b0);
      check("rd_to_tx_latency", lat, 2);

      // bad header, then out-of-range address
      send_byte(8'h12);
      repeat (2) @(negedge CLK);
      send_byte(8'hAA); send_byte(8'h10);
      repeat (3) @(negedge CLK);

      // transmitter backpressure
      reset_dut();
      send_byte(8'hAA); send_byte(8'h02); send_byte(8'h80);
      TX_BUSY = 1'b1;
      send_byte(8'hBB); send_byte(8'h02);
      leak = 1'b0;
      repeat (10) begin
         @(negedge CLK);
         if (TX_D_VLD) leak = 1'b1;
      end
      check("tx_held_while_busy", leak, 0);
      TX_BUSY = 1'b0;
      @(negedge CLK);
      check("tx_after_busy", TX_D_VLD, 1);
      check("tx_data_after_busy", TX_P_DATA, 8'h80);
      rd_busy = 1'b0;
      @(negedge CLK);

      // reset mid-frame discards the partial write
      send_byte(8'hAA); send_byte(8'h03);
      reset_dut();
      send_byte(8'h55);
      repeat (3) @(negedge CLK);

      // overrun while the read is in flight
      rd_delay = 3;
      send_byte(8'hBB); send_byte(8'h07);
      send_byte(8'hAA);
      wait_tx(lat, 1'b0);
      rd_delay = 0;

      // stray read-data strobe in IDLE
      inject_req++;
      repeat (4) @(negedge CLK);

`ifdef REGFILE_CMD_TIMEOUT_EN
      send_byte(8'hAA);
      frame.delete();
      err_q.push_back(1'b1);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge CLK);
         if (FRAME_ERR) begin
            lat = i;
            break;
         end
      end
      check("timeout_cycle", lat, 8);
      send_byte(8'hAA); send_byte(8'h01); send_byte(8'h77);
      repeat (2) @(negedge CLK);
`endif

      // randomized frames
      for (int n = 0; n < 80; n++) begin
         kind = $urandom_range(0, 5);
         case (kind)
            0, 1: begin
               send_byte(8'hAA);
               send_byte(8'($urandom_range(0, 15)));
               send_byte(8'($urandom));
            end
            2, 3: begin
               rd_delay = $urandom_range(0, 3);
               send_byte(8'hBB);
               send_byte(8'($urandom_range(0, 15)));
               if ($urandom_range(0, 3) == 0) send_byte(8'($urandom));
               wait_tx(lat, 1'b1);
            end
            4: begin
               b = 8'($urandom);
               if (b == 8'hAA || b == 8'hBB) b = 8'h00;
               send_byte(b);
            end
            default: begin
               send_byte(($urandom_range(0, 1) == 1) ? 8'hAA : 8'hBB);
               send_byte(8'($urandom_range(16, 255)));
            end
         endcase
         repeat ($urandom_range(0, 2)) @(negedge CLK);
      end

      repeat (10) @(negedge CLK);
      check("wr_queue_drained", wr_q.size(), 0);
      check("rd_queue_drained", rd_q.size(), 0);
      check("tx_queue_drained", tx_q.size(), 0);
      check("err_queue_drained", err_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
